out_port_scheduler: RTL and testbench

OUT_PORT_SCHEDULER -- requirements
Module: out_port_scheduler

---
 rtl/out_port_scheduler_pkg.sv | 16 +
 rtl/out_port_scheduler_fifo.sv | 62 ++++++
 rtl/out_port_scheduler.sv | 159 +++++++++++++++
 tb/tb_out_port_scheduler.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/out_port_scheduler_pkg.sv
// Shared constants for the output-port scheduler: default geometry and FSM encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package out_port_scheduler_pkg;

  // Default switch geometry
  localparam int PORT_NUB_DEF   = 4;
  localparam int DATA_WIDTH_DEF = 8;

  // Read-issue FSM: IDLE = nothing to read or no credit, READ = rd_en high this cycle
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } sched_state_t;

endpackage

// File: rtl/out_port_scheduler_fifo.sv
// Output buffer: stores data words tagged with their source port index.
// Latency: a word pushed at one edge is visible at the head from the next cycle.
// Backpressure: pushes when full and pops when empty are ignored; the caller's credit prevents overflow.
module sched_out_fifo #(
  parameter int DW    = 8,
  parameter int SW    = 2,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [DW-1:0]                push_data,
  input  logic [SW-1:0]                push_src,
  input  logic                         pop,
  output logic [DW-1:0]                head_data,
  output logic [SW-1:0]                head_src,
  output logic                         head_vld,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW+SW-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && (count != CW'(DEPTH));
  assign do_pop   = pop && (count != '0);
  assign head_vld = (count != '0);

  // Head word is forced to zero when empty so reset and idle outputs read as 0
  always_comb begin
    {head_src, head_data} = '0;
    if (head_vld) {head_src, head_data} = mem[rd_ptr];
  end

  // Pointers and occupancy; simultaneous push and pop leaves count unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array needs no reset: head is masked by count
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {push_src, push_data};
  end

endmodule

// File: rtl/out_port_scheduler.sv
// Output-port scheduler: round-robin reads from per-input switch queues into a credited output buffer (SCHED_BURST_EN enables burst grants).
// Latency: rd_en to tx_valid is 2 cycles into an empty buffer; data_in arrives one cycle after rd_en.
// Backpressure: reads stop once buffered plus in-flight words reach OUT_DEPTH; head holds while tx_ready is low.
module out_port_scheduler
  import out_port_scheduler_pkg::*;
#(
  parameter int PORT_NUB   = PORT_NUB_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int OUT_DEPTH  = 4,
  parameter int BURST_LEN  = 4,
  localparam int WIDTH_SEL = $clog2(PORT_NUB)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PORT_NUB-1:0]   empty,
  output logic [WIDTH_SEL-1:0]  rd_sel,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [WIDTH_SEL-1:0]  tx_src
);

  sched_state_t                      state_q;
  sched_state_t                      state_d;
  logic [WIDTH_SEL-1:0]              last_grant_q;
  logic [WIDTH_SEL-1:0]              rr_base;
  logic [WIDTH_SEL-1:0]              cand;
  logic [WIDTH_SEL-1:0]              rr_idx;
  logic                              rr_found;
  logic [WIDTH_SEL-1:0]              pick_idx;
  logic                              src_ok;
  logic                              credit_ok;
  logic                              inflight_q;
  logic [WIDTH_SEL-1:0]              inflight_src_q;
  logic [$clog2(OUT_DEPTH+1)-1:0]    fifo_count;

  // Credit counts buffered plus in-flight words; a same-cycle pop is not credited
  assign credit_ok = (int'(fifo_count) + int'(inflight_q)) < OUT_DEPTH;

  // Round-robin search for the first non-empty queue after the base index
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int k = 1; k <= PORT_NUB; k++) begin
      cand = WIDTH_SEL'((int'(rr_base) + k) % PORT_NUB);
      if (!rr_found && !empty[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

`ifdef SCHED_BURST_EN
  localparam int BCW = $clog2(BURST_LEN + 1);

  logic [BCW-1:0]       burst_cnt_q;
  logic [BCW-1:0]       burst_cnt_nxt;
  logic [WIDTH_SEL-1:0] burst_src_q;
  logic                 burst_open_q;
  logic                 hold;

  // An open burst keeps the grant while its queue still has data
  assign hold          = burst_open_q && !empty[burst_src_q];
  assign src_ok        = hold || rr_found;
  assign pick_idx      = hold ? burst_src_q : rr_idx;
  assign burst_cnt_nxt = hold ? burst_cnt_q + 1'b1 : '0;
  // If the burst source ran dry, move on past it rather than past the previous burst
  assign rr_base       = burst_open_q ? burst_src_q : last_grant_q;

  // Burst bookkeeping: last_grant only advances when a burst closes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_cnt_q  <= '0;
      burst_src_q  <= '0;
      burst_open_q <= 1'b0;
      last_grant_q <= WIDTH_SEL'(PORT_NUB - 1);
    end else if (rd_en) begin
      if (burst_cnt_nxt == BCW'(BURST_LEN - 1)) begin
        last_grant_q <= rd_sel;
        burst_open_q <= 1'b0;
        burst_cnt_q  <= '0;
      end else begin
        burst_src_q  <= rd_sel;
        burst_open_q <= 1'b1;
        burst_cnt_q  <= burst_cnt_nxt;
      end
    end else if (burst_open_q) begin
      // Source or credit exhausted mid-burst: close it here
      last_grant_q <= burst_src_q;
      burst_open_q <= 1'b0;
      burst_cnt_q  <= '0;
    end
  end
`else
  assign src_ok   = rr_found;
  assign pick_idx = rr_idx;
  assign rr_base  = last_grant_q;

  // Per-word round-robin: every read moves the priority pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        last_grant_q <= WIDTH_SEL'(PORT_NUB - 1);
    else if (rd_en) last_grant_q <= rd_sel;
  end
`endif

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: READ whenever a source is eligible and credit remains
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (src_ok && credit_ok)    state_d = ST_READ;
      ST_READ: if (!(src_ok && credit_ok)) state_d = ST_IDLE;
      default:                             state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: read strobe is combinational so empty is honoured the same cycle
  always_comb begin
    rd_en  = (state_d == ST_READ) && !rst;
    rd_sel = rd_en ? pick_idx : '0;
  end

  // Track the read whose data arrives next cycle; reset drops it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q     <= 1'b0;
      inflight_src_q <= '0;
    end else begin
      inflight_q     <= rd_en;
      inflight_src_q <= rd_sel;
    end
  end

  sched_out_fifo #(
    .DW    (DATA_WIDTH),
    .SW    (WIDTH_SEL),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (data_in),
    .push_src  (inflight_src_q),
    .pop       (tx_valid && tx_ready),
    .head_data (tx_data),
    .head_src  (tx_src),
    .head_vld  (tx_valid),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_out_port_scheduler.sv
// Directed bench for out_port_scheduler with a small switch-queue model.
// Words from queue s carry {s, per-queue sequence} so source and order are visible.
module tb_out_port_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] empty;
  logic [1:0] rd_sel;
  logic       rd_en;
  logic [7:0] data_in;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [1:0] tx_src;

  int n_chk = 0;
  int n_err = 0;
  int q_cnt [4];
  int q_seq [4];
  int pulses;

  logic [1:0] e_sel [12];
  logic [7:0] e_dat [12];

  always #5 clk = ~clk;

  out_port_scheduler dut (
    .clk      (clk),
    .rst      (rst),
    .empty    (empty),
    .rd_sel   (rd_sel),
    .rd_en    (rd_en),
    .data_in  (data_in),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_src   (tx_src)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic upd_empty();
    for (int i = 0; i < 4; i++) empty[i] = (q_cnt[i] == 0);
  endtask

  task automatic set_queues(input int c0, input int c1, input int c2, input int c3);
    q_cnt[0] = c0; q_cnt[1] = c1; q_cnt[2] = c2; q_cnt[3] = c3;
    for (int i = 0; i < 4; i++) q_seq[i] = 0;
    upd_empty();
    #1;
  endtask

  // One clock: the switch model pops the read queue and presents its word the next cycle
  task automatic tick();
    logic       r;
    logic [1:0] s;
    #1;
    r = rd_en;
    s = rd_sel;
    @(posedge clk);
    #1;
    if (r) begin
      data_in = {s, 6'(q_seq[s])};
      q_seq[s]++;
      q_cnt[s]--;
    end else begin
      data_in = 8'h00;
    end
    upd_empty();
    #1;
  endtask

  initial begin
    // Reset state with every queue holding data
    rst = 1'b1; tx_ready = 1'b1; data_in = 8'h00;
    set_queues(100, 100, 100, 100);
    tick(); tick();
    check("rst_rd_en",    rd_en,    0);
    check("rst_rd_sel",   rd_sel,   0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data",  tx_data,  0);
    check("rst_tx_src",   tx_src,   0);

    // Release with all queues empty: nothing happens for 20 cycles
    set_queues(0, 0, 0, 0);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      check("idle_rd_en",    rd_en,    0);
      check("idle_tx_valid", tx_valid, 0);
      tick();
    end

    // Queues 1 and 3 non-empty, free-flowing output
`ifdef SCHED_BURST_EN
    e_sel = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
    e_dat = '{8'h00, 8'h00, 8'h40, 8'h41, 8'h42, 8'h43, 8'hC0, 8'hC1, 8'h00, 8'h00, 8'h00, 8'h00};
`else
    e_sel = '{2'd1, 2'd3, 2'd1, 2'd3, 2'd1, 2'd3, 2'd1, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
    e_dat = '{8'h00, 8'h00, 8'h40, 8'hC0, 8'h41, 8'hC1, 8'h42, 8'hC2, 8'h00, 8'h00, 8'h00, 8'h00};
`endif
    set_queues(0, 100, 0, 100);
    for (int k = 0; k < 8; k++) begin
      check("rr_rd_en",    rd_en,    1);
      check("rr_rd_sel",   rd_sel,   e_sel[k]);
      check("rr_tx_valid", tx_valid, (k >= 2));
      if (k >= 2) begin
        check("rr_tx_data", tx_data, e_dat[k]);
        check("rr_tx_src",  tx_src,  e_dat[k][7:6]);
      end
      tick();
    end
    set_queues(0, 0, 0, 0);
    repeat (4) tick();
    check("rr_drained", tx_valid, 0);

    // All queues non-empty, output stalled: credit allows exactly 4 reads
`ifdef SCHED_BURST_EN
    e_sel = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    e_dat = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`else
    e_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    e_dat = '{8'h00, 8'h40, 8'h80, 8'hC0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`endif
    tx_ready = 1'b0;
    set_queues(100, 100, 100, 100);
    for (int k = 0; k < 10; k++) begin
      check("bp_rd_en", rd_en, (k < 4));
      if (k < 4) check("bp_rd_sel", rd_sel, e_sel[k]);
      if (k >= 2) begin
        check("bp_tx_valid", tx_valid, 1);
        check("bp_hold_data", tx_data, e_dat[0]);
        check("bp_hold_src",  tx_src,  e_dat[0][7:6]);
      end
      tick();
    end
    tx_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("drain_valid", tx_valid, 1);
      check("drain_data",  tx_data,  e_dat[k]);
      check("drain_src",   tx_src,   e_dat[k][7:6]);
      tick();
    end
    set_queues(0, 0, 0, 0);
    repeat (8) tick();

    // Only queue 2 holds a single word
    set_queues(0, 0, 1, 0);
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      if (rd_en) pulses++;
      if (k == 0) begin
        check("one_rd_en",  rd_en,  1);
        check("one_rd_sel", rd_sel, 2);
      end
      if (k == 2) begin
        check("one_tx_valid", tx_valid, 1);
        check("one_tx_src",   tx_src,   2);
        check("one_tx_data",  tx_data,  8'h80);
      end
      if (k == 3) check("one_tx_gone", tx_valid, 0);
      tick();
    end
    check("one_pulses", pulses, 1);

    // Queues 0 and 1 always non-empty
`ifdef SCHED_BURST_EN
    e_sel = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0};
`else
    e_sel = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1};
`endif
    set_queues(100, 100, 0, 0);
    for (int k = 0; k < 12; k++) begin
      check("pair_rd_en",  rd_en,  1);
      check("pair_rd_sel", rd_sel, e_sel[k]);
      tick();
    end
    set_queues(0, 0, 0, 0);
    repeat (6) tick();

    // Reset with two words buffered and one read in flight
    tx_ready = 1'b0;
    set_queues(100, 100, 100, 100);
    tick(); tick(); tick();
    check("mid_pre_valid", tx_valid, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", tx_valid, 0);
    check("mid_rst_rd_en", rd_en,    0);
    tick(); tick();
    check("mid_rst_rd_sel", rd_sel, 0);
    set_queues(0, 0, 0, 0);
    tx_ready = 1'b1;
    rst = 1'b0;
    data_in = 8'hEE;
    for (int k = 0; k < 6; k++) begin
      check("mid_no_stale", tx_valid, 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
